qu_rob: RTL

Reorder buffer for the Qu out-of-order core. It allocates one entry per dispatched instruction in program order and tracks each entry's state as results come back from the execution units. It retires completed entries in order to the physical register file commit path and triggers a pipeline flush when a mispredicted branch reaches the head. It sits between dispatch/reservation stations (upstream) and architectural commit (downstream).

---
 rtl/qu_common_pkg.sv | 33 +++
 rtl/qu_rob_ptr.sv | 31 +++
 rtl/qu_rob.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/qu_common_pkg.sv
// Shared Qu core types: ROB entry layout, entry states and sizing constants.
package qu_common;

  localparam int ROB_DEPTH          = 8;
  localparam int ROB_ADDR_WIDTH     = $clog2(ROB_DEPTH);
  localparam int PHY_RF_ADDR_WIDTH  = 6;

  typedef logic [PHY_RF_ADDR_WIDTH-1:0] phy_rf_addr_t;
  typedef logic [ROB_ADDR_WIDTH-1:0]    rob_addr_t;
  typedef logic [ROB_ADDR_WIDTH:0]      rob_count_t;

  typedef enum logic [1:0] {
    ROB_STATE_EMPTY   = 2'd0,
    ROB_STATE_PENDING = 2'd1,
    ROB_STATE_EXECUTE = 2'd2,
    ROB_STATE_RETIRED = 2'd3
  } rob_state_e;

  typedef struct packed {
    rob_state_e   state;
    phy_rf_addr_t dest;
    logic [31:0]  value;
    logic         mispredicted_branch;
  } rob_cell_t;

  localparam rob_cell_t ROB_CELL_RESET = '{
    state:               ROB_STATE_EMPTY,
    dest:                '0,
    value:               '0,
    mispredicted_branch: 1'b0
  };

endpackage

// File: rtl/qu_rob_ptr.sv
// Wrap-around pointer with increment and synchronous clear; the pointer width
// is log2 of a power-of-two depth, so natural overflow is the modulo wrap.
module qu_rob_ptr #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] ptr_o
);

  logic [WIDTH-1:0] ptr_q, ptr_d;

  // Clear wins over increment so a flush always lands the pointer at 0.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (inc_i) ptr_d = ptr_q + WIDTH'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only; mixing in
  // blocking assignments here creates simulation/synthesis ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/qu_rob.sv
// Qu reorder buffer: in-order allocate/commit, out-of-order issue/writeback,
// flush on mispredicted head. Define QU_ROB_FORWARD_EN to build operand forwarding.
module qu_rob
  import qu_common::*;
#(
  parameter int ROB_DEPTH = qu_common::ROB_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,

  input  logic                       alloc_valid_i,
  input  phy_rf_addr_t               alloc_dest_i,
  output logic                       alloc_ready_o,
  output rob_addr_t                  alloc_addr_o,

  input  logic                       issue_valid_i,
  input  rob_addr_t                  issue_rob_addr_i,

  input  logic                       wb_valid_i,
  input  rob_addr_t                  wb_rob_addr_i,
  input  logic [31:0]                wb_value_i,
  input  logic                       wb_mispredicted_i,

  output logic                       commit_valid_o,
  input  logic                       commit_ready_i,
  output phy_rf_addr_t               commit_dest_o,
  output logic [31:0]                commit_value_o,
  output logic                       flush_o,

  input  rob_addr_t                  fwd_addr_j_i,
  input  rob_addr_t                  fwd_addr_k_i,
  output logic [31:0]                fwd_value_j_o,
  output logic [31:0]                fwd_value_k_o,
  output logic                       fwd_ready_j_o,
  output logic                       fwd_ready_k_o,

  output logic [$clog2(ROB_DEPTH):0] count_o
);

  localparam int                CW         = $clog2(ROB_DEPTH) + 1;
  localparam logic [CW-1:0]     FULL_COUNT = CW'(ROB_DEPTH);

  rob_cell_t         cells_q [ROB_DEPTH];
  rob_cell_t         cells_d [ROB_DEPTH];
  logic [CW-1:0]     count_q, count_d;
  rob_addr_t         head, tail;

  logic              alloc_fire;
  logic              commit_fire;
  logic              flush;

  qu_rob_ptr #(.WIDTH(ROB_ADDR_WIDTH)) u_head_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .inc_i (commit_fire),
    .ptr_o (head)
  );

  qu_rob_ptr #(.WIDTH(ROB_ADDR_WIDTH)) u_tail_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .inc_i (alloc_fire),
    .ptr_o (tail)
  );

  // Full blocks allocation even when the head commits this cycle (no bypass).
  assign alloc_ready_o  = (count_q != FULL_COUNT);
  assign alloc_addr_o   = tail;
  assign alloc_fire     = alloc_valid_i & alloc_ready_o;

  assign commit_valid_o = (count_q != '0) && (cells_q[head].state == ROB_STATE_RETIRED);
  assign commit_dest_o  = cells_q[head].dest;
  assign commit_value_o = cells_q[head].value;
  assign commit_fire    = commit_valid_o & commit_ready_i;
  assign flush          = commit_fire & cells_q[head].mispredicted_branch;
  assign flush_o        = flush;

  // NOTE: every combinational output gets a default before any conditional
  // update; a path that leaves a variable unassigned would infer a latch.
  always_comb begin
    cells_d = cells_q;
    count_d = count_q;
    if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) cells_d[i].state = ROB_STATE_EMPTY;
      count_d = '0;
    end else begin
      if (issue_valid_i && cells_q[issue_rob_addr_i].state == ROB_STATE_PENDING)
        cells_d[issue_rob_addr_i].state = ROB_STATE_EXECUTE;

      // Writeback after issue so a same-cycle issue+writeback ends RETIRED.
      if (wb_valid_i && (cells_q[wb_rob_addr_i].state == ROB_STATE_PENDING ||
                         cells_q[wb_rob_addr_i].state == ROB_STATE_EXECUTE)) begin
        cells_d[wb_rob_addr_i].state               = ROB_STATE_RETIRED;
        cells_d[wb_rob_addr_i].value               = wb_value_i;
        cells_d[wb_rob_addr_i].mispredicted_branch = wb_mispredicted_i;
      end

      if (commit_fire) cells_d[head].state = ROB_STATE_EMPTY;

      if (alloc_fire) begin
        cells_d[tail] = '{
          state:               ROB_STATE_PENDING,
          dest:                alloc_dest_i,
          value:               '0,
          mispredicted_branch: 1'b0
        };
      end

      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: the entry array is reset in full, not just its state field, so the
  // commit and forwarding data outputs read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROB_DEPTH; i++) cells_q[i] <= ROB_CELL_RESET;
      count_q <= '0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) cells_q[i] <= cells_d[i];
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

`ifdef QU_ROB_FORWARD_EN
  assign fwd_value_j_o = cells_q[fwd_addr_j_i].value;
  assign fwd_value_k_o = cells_q[fwd_addr_k_i].value;
  assign fwd_ready_j_o = (cells_q[fwd_addr_j_i].state == ROB_STATE_RETIRED);
  assign fwd_ready_k_o = (cells_q[fwd_addr_k_i].state == ROB_STATE_RETIRED);
`else
  // Without forwarding, reservation stations wait on the common data bus.
  logic unused_fwd_addr;
  assign unused_fwd_addr = ^{fwd_addr_j_i, fwd_addr_k_i};
  assign fwd_value_j_o   = '0;
  assign fwd_value_k_o   = '0;
  assign fwd_ready_j_o   = 1'b0;
  assign fwd_ready_k_o   = 1'b0;
`endif

endmodule
